// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the mem_responder.
// The initiator drives requests and accepts responses (master); the
// responder accepts requests and drives responses (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_wr;
    logic [15:0] resp_rdata;
    logic        resp_ready;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_wr, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_wr, resp_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed latency.
// A request is accepted in IDLE, waits in BUSY for LATENCY-1 cycles,
// and is answered in RESP until the initiator takes the response.
// Stores commit and loads sample the array on the edge entering RESP,
// so a reset before that edge abandons the operation cleanly.
module mem_responder #(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    // BUSY counter start value; unused when LATENCY is 1 (no BUSY state).
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_wr_q, resp_wr_d;
    logic [15:0]         resp_rdata_q, resp_rdata_d;

    // Operation presented to the array on the edge entering RESP. When
    // LATENCY is 1 it comes straight from the bus, otherwise from capture.
    logic                enter_resp_s;
    logic                op_wr_s;
    logic [ADDR_W-1:0]   op_idx_s;
    logic [15:0]         op_wdata_s;
    logic                mem_we_s;

    logic [15:0]         mem_q [DEPTH];

    // Address bit 0 and bits above the word index are deliberately ignored.
    logic                unused_addr_s;
    assign unused_addr_s = ^bus.req_addr;

    // Next-state, capture and response logic for the IDLE/BUSY/RESP FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_wr_d    = resp_wr_q;
        resp_rdata_d = resp_rdata_q;
        enter_resp_s = 1'b0;
        op_wr_s      = wr_q;
        op_idx_s     = idx_q;
        op_wdata_s   = wdata_q;
        mem_we_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    idx_d   = bus.req_addr[ADDR_W:1];
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                        op_wr_s      = bus.req_wr;
                        op_idx_s     = bus.req_addr[ADDR_W:1];
                        op_wdata_s   = bus.req_wdata;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_wr_d    = 1'b0;
                    resp_rdata_d = 16'h0000;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp_s) begin
            resp_valid_d = 1'b1;
            resp_wr_d    = op_wr_s;
            mem_we_s     = op_wr_s;
            if (op_wr_s) begin
                resp_rdata_d = 16'h0000;
            end else begin
                resp_rdata_d = mem_q[op_idx_s];
            end
        end else begin
            mem_we_s = 1'b0;
        end

        // Registered ready: high exactly in the cycles spent in IDLE.
        req_ready_d = (state_d == ST_IDLE);
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 16'h0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_wr_q    <= 1'b0;
            resp_rdata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_wr_q    <= resp_wr_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Word array: cleared by reset, written only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i[ADDR_W-1:0]] <= 16'h0000;
            end
        end else if (mem_we_s) begin
            mem_q[op_idx_s] <= op_wdata_s;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_wr    = resp_wr_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=4 and one
// with LATENCY=1. Inputs are driven and outputs sampled 1 time unit after
// each rising edge; "cycle N" is the interval after the Nth edge.
module tb_mem_responder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_responder_if if4 ();
    mem_responder_if if1 ();

    mem_responder #(.ADDR_W(13), .LATENCY(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    mem_responder #(.ADDR_W(13), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed run is a few hundred cycles at most.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic rr);
        if4.req_valid  = v;
        if4.req_wr     = wr;
        if4.req_addr   = a;
        if4.req_wdata  = d;
        if4.resp_ready = rr;
    endtask

    task automatic drive1(input logic v, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic rr);
        if1.req_valid  = v;
        if1.req_wr     = wr;
        if1.req_addr   = a;
        if1.req_wdata  = d;
        if1.resp_ready = rr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({if4.req_ready, if4.resp_valid, if4.resp_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset4_ctrl: got %b expected 100", {if4.req_ready, if4.resp_valid, if4.resp_wr});
        end
        n_checks++;
        if (if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset4_rdata: got %h expected 0000", if4.resp_rdata);
        end
        n_checks++;
        if ({if1.req_ready, if1.resp_valid, if1.resp_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset1_ctrl: got %b expected 100", {if1.req_ready, if1.resp_valid, if1.resp_wr});
        end
        n_checks++;
        if (if1.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset1_rdata: got %h expected 0000", if1.resp_rdata);
        end
    endtask

    task automatic test_load_after_reset();
        drive4(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({if4.resp_valid, if4.req_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL load_busy c%0d: got valid/ready %b expected 00", c, {if4.resp_valid, if4.req_ready});
            end
            step();
        end
        n_checks++;
        if ({if4.resp_valid, if4.resp_wr, if4.req_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_resp_c4: got valid/wr/ready %b expected 100", {if4.resp_valid, if4.resp_wr, if4.req_ready});
        end
        n_checks++;
        if (if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_rdata_c4: got %h expected 0000", if4.resp_rdata);
        end
        step();
        n_checks++;
        if ({if4.resp_valid, if4.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL load_idle_c5: got valid/ready %b expected 01", {if4.resp_valid, if4.req_ready});
        end
    endtask

    task automatic test_store_load();
        drive4(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({if4.resp_valid, if4.req_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL store_busy c%0d: got valid/ready %b expected 00", c, {if4.resp_valid, if4.req_ready});
            end
            step();
        end
        n_checks++;
        if ({if4.resp_valid, if4.resp_wr, if4.req_ready} !== 3'b110 || if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL store_ack_c4: got valid/wr/ready %b rdata %h expected 110 rdata 0000",
                     {if4.resp_valid, if4.resp_wr, if4.req_ready}, if4.resp_rdata);
        end
        step();
        n_checks++;
        if ({if4.resp_valid, if4.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_idle_c5: got valid/ready %b expected 01", {if4.resp_valid, if4.req_ready});
        end
        drive4(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        n_checks++;
        if ({if4.resp_valid, if4.resp_wr} !== 2'b10 || if4.resp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_after_store: got valid/wr %b rdata %h expected 10 rdata beef",
                     {if4.resp_valid, if4.resp_wr}, if4.resp_rdata);
        end
        step();
    endtask

    task automatic test_backpressure();
        drive4(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        step();
        // Ignored request plus changed inputs while the load is in flight.
        drive4(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b0);
        step();
        step();
        step();
        for (int c = 4; c <= 9; c++) begin
            n_checks++;
            if ({if4.resp_valid, if4.resp_wr, if4.req_ready} !== 3'b100 || if4.resp_rdata !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL hold c%0d: got valid/wr/ready %b rdata %h expected 100 rdata beef",
                         c, {if4.resp_valid, if4.resp_wr, if4.req_ready}, if4.resp_rdata);
            end
            step();
        end
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++;
        if ({if4.resp_valid, if4.req_ready} !== 2'b10 || if4.resp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL hold_c10: got valid/ready %b rdata %h expected 10 rdata beef",
                     {if4.resp_valid, if4.req_ready}, if4.resp_rdata);
        end
        step();
        n_checks++;
        if ({if4.resp_valid, if4.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL after_handshake_c11: got valid/ready %b expected 01", {if4.resp_valid, if4.req_ready});
        end
        // The ignored store to 0x0010 must not have landed.
        drive4(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        n_checks++;
        if (if4.resp_valid !== 1'b1 || if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL ignored_store: got valid %b rdata %h expected 1 rdata 0000", if4.resp_valid, if4.resp_rdata);
        end
        step();
    endtask

    task automatic test_alias();
        drive4(1'b1, 1'b1, 16'h0002, 16'h1234, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        step();
        drive4(1'b1, 1'b0, 16'h4002, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        n_checks++;
        if (if4.resp_valid !== 1'b1 || if4.resp_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL alias_4002: got valid %b rdata %h expected 1 rdata 1234", if4.resp_valid, if4.resp_rdata);
        end
        step();
        // Odd byte address selects the same word.
        drive4(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        n_checks++;
        if (if4.resp_valid !== 1'b1 || if4.resp_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL alias_0003: got valid %b rdata %h expected 1 rdata 1234", if4.resp_valid, if4.resp_rdata);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        drive4(1'b1, 1'b1, 16'h0040, 16'h5555, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({if4.req_ready, if4.resp_valid, if4.resp_wr} !== 3'b100 || if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_c3: got ready/valid/wr %b rdata %h expected 100 rdata 0000",
                     {if4.req_ready, if4.resp_valid, if4.resp_wr}, if4.resp_rdata);
        end
        step();
        n_checks++;
        if (if4.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_resp: got valid %b expected 0", if4.resp_valid);
        end
        drive4(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1);
        step();
        drive4(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        step();
        step();
        n_checks++;
        if ({if4.resp_valid, if4.resp_wr} !== 2'b10 || if4.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL abandoned_store: got valid/wr %b rdata %h expected 10 rdata 0000",
                     {if4.resp_valid, if4.resp_wr}, if4.resp_rdata);
        end
        step();
    endtask

    task automatic test_latency1();
        drive1(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        step();
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++;
        if ({if1.resp_valid, if1.resp_wr, if1.req_ready} !== 3'b100 || if1.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL l1_load_c1: got valid/wr/ready %b rdata %h expected 100 rdata 0000",
                     {if1.resp_valid, if1.resp_wr, if1.req_ready}, if1.resp_rdata);
        end
        step();
        drive1(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1);
        step();
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++;
        if ({if1.resp_valid, if1.resp_wr, if1.req_ready} !== 3'b110 || if1.resp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL l1_store_c1: got valid/wr/ready %b rdata %h expected 110 rdata 0000",
                     {if1.resp_valid, if1.resp_wr, if1.req_ready}, if1.resp_rdata);
        end
        step();
        n_checks++;
        if ({if1.resp_valid, if1.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL l1_idle_c2: got valid/ready %b expected 01", {if1.resp_valid, if1.req_ready});
        end
        drive1(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1);
        step();
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++;
        if (if1.resp_valid !== 1'b1 || if1.resp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL l1_load_beef: got valid %b rdata %h expected 1 rdata beef", if1.resp_valid, if1.resp_rdata);
        end
        step();
        // Held response with store pulses that must be ignored.
        drive1(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        step();
        for (int c = 1; c <= 3; c++) begin
            drive1(1'b1, 1'b1, 16'h0020, 16'h1111, 1'b0);
            n_checks++;
            if (if1.resp_valid !== 1'b1 || if1.resp_rdata !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL l1_hold c%0d: got valid %b rdata %h expected 1 rdata beef", c, if1.resp_valid, if1.resp_rdata);
            end
            step();
        end
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        step();
        for (int c = 5; c <= 7; c++) begin
            n_checks++;
            if ({if1.resp_valid, if1.req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL l1_no_extra c%0d: got valid/ready %b expected 01", c, {if1.resp_valid, if1.req_ready});
            end
            step();
        end
        drive1(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);
        step();
        drive1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++;
        if (if1.resp_valid !== 1'b1 || if1.resp_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL l1_ignored_store: got valid %b rdata %h expected 1 rdata beef", if1.resp_valid, if1.resp_rdata);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_load_after_reset();
        test_store_load();
        test_backpressure();
        test_alias();
        test_reset_midflight();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 13, sets the word-address width, giving 2^ADDR_W 16-bit words.
REQ-002 Parameter LATENCY, default 4, sets the cycles from request acceptance to first resp_valid; legal range 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset, sampled on posedge clk.
REQ-005 Port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 Port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-007 Port req_addr, input, 16 bits: byte address; bit 0 ignored; word index = req_addr[ADDR_W:1].
REQ-008 Port req_wdata, input, 16 bits: store data.
REQ-009 Port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-010 Port resp_valid, output, 1 bit: a response is presented.
REQ-011 Port resp_wr, output, 1 bit: echo of req_wr for the presented response.
REQ-012 Port resp_rdata, output, 16 bits: load data; 16'h0000 for store responses.
REQ-013 Port resp_ready, input, 1 bit: the initiator accepts the response this cycle.

Function
REQ-014 The block shall implement a three-state FSM (IDLE, BUSY, RESP) with exactly one outstanding request.
REQ-015 req_ready shall be 1 only in IDLE and never depend combinationally on req_valid.
REQ-016 A request shall be accepted on the edge where req_valid & req_ready; req_wr, word index and req_wdata are captured on that edge.
REQ-017 Acceptance in cycle T shall produce resp_valid first in cycle T+LATENCY: IDLE -> BUSY for LATENCY-1 cycles -> RESP; with LATENCY=1, IDLE -> RESP directly.
REQ-018 The BUSY down-counter shall be 4 bits, load LATENCY-2 on entry, and exit to RESP when it reads 0.
REQ-019 A store shall commit to the array on the edge entering RESP, with resp_rdata=16'h0000 and resp_wr=1.
REQ-020 A load shall sample the array on the edge entering RESP, with resp_rdata held stable and resp_wr=0.
REQ-021 In RESP, resp_valid, resp_wr and resp_rdata shall hold until resp_valid & resp_ready, and the FSM then returns to IDLE on that edge.
REQ-022 req_ready shall be 0 in the handshake cycle, so requests are never back-to-back; the minimum request spacing is LATENCY+1 cycles.
REQ-023 req_addr bits above ADDR_W shall be ignored, so addresses alias (wrap) modulo 2^(ADDR_W+1) bytes.
REQ-024 resp_ready asserted outside RESP shall be ignored.
REQ-025 req_valid asserted while not in IDLE shall be ignored, with no capture and no side effects.
REQ-026 Input changes after acceptance shall not affect the in-flight operation.

Reset
REQ-027 rst shall take priority over all other inputs on the same edge.
REQ-028 After reset: state IDLE, req_ready=1, resp_valid=0, resp_wr=0, resp_rdata=16'h0000, counter=0.
REQ-029 Reset shall clear every array word to 16'h0000.
REQ-030 Reset during BUSY or RESP shall abandon the in-flight request, and an abandoned store shall not commit.

Verification
REQ-031 Reset, then load from 0x0010 (LATENCY=4, accepted in cycle 0) -> resp_valid in cycle 4, resp_rdata=0x0000, resp_wr=0.
REQ-032 Store 0xBEEF to 0x0020 with resp_ready=1, then load 0x0021 -> store ack resp_wr=1 in cycle 4; load returns 0xBEEF; req_ready=0 in cycles 1-4 and 1 from cycle 5.
REQ-033 Load with resp_ready held 0 for 6 cycles after resp_valid -> resp_valid and resp_rdata stable for 7 cycles; req_ready=1 only in the cycle after the handshake.
REQ-034 Store 0x1234 to 0x0002, then load 0x4002 (ADDR_W=13) -> returns 0x1234 (alias).
REQ-035 Store 0x5555 to 0x0040 with rst asserted in cycle 2 -> outputs at reset values in cycle 3; subsequent load of 0x0040 returns 0x0000.
REQ-036 Repeat REQ-031 and REQ-032 with LATENCY=1 -> resp_valid in cycle 1; req_valid pulses during BUSY or RESP produce no extra responses.
